// File: rtl/counter_link_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_link_pkg
//  Brief    : Command codes, frame tags and TX state encoding shared by the
//             counter link engine files.
//  Revision : 1.0  initial release
// ============================================================================
package counter_link_pkg;

   localparam logic [7:0] CMD_ACK1  = 8'h00;
   localparam logic [7:0] CMD_ACK2  = 8'h01;
   localparam logic [7:0] CMD_TRIG1 = 8'h02;
   localparam logic [7:0] CMD_TRIG2 = 8'h03;

   localparam logic [7:0] TAG1 = 8'h00;
   localparam logic [7:0] TAG2 = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TAG  = 2'd1,
      ST_DATA = 2'd2
   } txState_t;

   // Number of whole bytes needed to carry a value of the given width
   function automatic int bytesFor(input int width);
      return (width + 7) / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_link_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_link_if
//  Brief    : Byte-stream link toward the USB bridge: TX with ready/valid,
//             RX with valid only.
//  Revision : 1.0  initial release
// ============================================================================
interface counter_link_if;

   logic [7:0] txData;
   logic       txValid;
   logic       txReady;
   logic [7:0] rxData;
   logic       rxValid;

   modport master (
      output txData,
      output txValid,
      input  txReady,
      input  rxData,
      input  rxValid
   );

   modport slave (
      input  txData,
      input  txValid,
      output txReady,
      output rxData,
      output rxValid
   );

endinterface
`default_nettype wire

// File: rtl/counter_link_engine_stretch.sv
`default_nettype none
// ============================================================================
//  Module   : link_pulse_stretch
//  Brief    : Restartable down-counter turning a 1-cycle start into a level
//             held for pLATCH_CYCLES cycles.
//  Revision : 1.0  initial release
// ============================================================================
module link_pulse_stretch #(
   parameter int pLATCH_CYCLES = 4
) (
   input  wire logic iCLK,
   input  wire logic iRST,
   input  wire logic iStart,
   output logic      oLevel
);

   localparam int c_CNT_W = $clog2(pLATCH_CYCLES + 1);

   logic [c_CNT_W-1:0] r_remain;

   // A start while already high simply reloads the count
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_remain <= '0;
         oLevel   <= 1'b0;
      end else if (iStart) begin
         r_remain <= c_CNT_W'(pLATCH_CYCLES - 1);
         oLevel   <= 1'b1;
      end else if (r_remain != '0) begin
         r_remain <= r_remain - c_CNT_W'(1);
      end else begin
         oLevel   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_link_engine.sv
`default_nettype none
// ============================================================================
//  Module   : counter_link_engine
//  Brief    : Frames latched counter values onto the host byte stream and
//             decodes host commands into latch releases and triggers.
//  Revision : 1.0  initial release
// ============================================================================
module counter_link_engine
   import counter_link_pkg::*;
#(
   parameter int pWIDTH        = 40,
   parameter int pLATCH_CYCLES = 4
) (
   input  wire logic              iCLK,
   input  wire logic              iRST,
   input  wire logic              iRdy1,
   input  wire logic [pWIDTH-1:0] iCount1,
   input  wire logic              iRdy2,
   input  wire logic [pWIDTH-1:0] iCount2,
   output logic                   oResetLatch1,
   output logic                   oResetLatch2,
   output logic                   oLatch1,
   output logic                   oLatch2,
   output logic                   oProtoErr,
   counter_link_if.master         link
);

   localparam int pBYTES  = bytesFor(pWIDTH);
   localparam int c_IDX_W = $clog2(pBYTES + 1);

   txState_t              r_txState;
   logic [7:0]            r_txData;
   logic                  r_txValid;
   logic [pBYTES*8-1:0]   r_payload;
   logic [c_IDX_W-1:0]    r_idx;
   logic                  r_ch2;
   logic                  r_sent1;
   logic                  r_sent2;

   logic                  w_accept;
   logic                  w_elig1;
   logic                  w_elig2;
   logic                  w_lastByte;
   logic [pBYTES*8-1:0]   w_snap;
   logic                  w_ack1Ok;
   logic                  w_ack2Ok;
   logic                  w_err;
   logic                  w_trig1;
   logic                  w_trig2;

   assign link.txData  = r_txData;
   assign link.txValid = r_txValid;

   assign w_accept   = r_txValid && link.txReady;
   assign w_elig1    = iRdy1 && !r_sent1;
   assign w_elig2    = iRdy2 && !r_sent2;
   assign w_lastByte = (r_idx == c_IDX_W'(pBYTES - 1));

   // Zero-pad the chosen counter up to a whole number of bytes
   always_comb begin
      w_snap              = '0;
      w_snap[pWIDTH-1:0]  = w_elig1 ? iCount1 : iCount2;
   end

   // An ack only counts once the channel's frame has fully left
   assign w_ack1Ok = link.rxValid && (link.rxData == CMD_ACK1) && r_sent1;
   assign w_ack2Ok = link.rxValid && (link.rxData == CMD_ACK2) && r_sent2;
   assign w_trig1  = link.rxValid && (link.rxData == CMD_TRIG1);
   assign w_trig2  = link.rxValid && (link.rxData == CMD_TRIG2);
   assign w_err    = link.rxValid &&
                     (((link.rxData == CMD_ACK1) && !r_sent1) ||
                      ((link.rxData == CMD_ACK2) && !r_sent2) ||
                      (link.rxData > CMD_TRIG2));

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_txState <= ST_IDLE;
         r_txData  <= 8'h00;
         r_txValid <= 1'b0;
         r_payload <= '0;
         r_idx     <= '0;
         r_ch2     <= 1'b0;
         r_sent1   <= 1'b0;
         r_sent2   <= 1'b0;
      end else begin
         if (w_ack1Ok) r_sent1 <= 1'b0;
         if (w_ack2Ok) r_sent2 <= 1'b0;

         case (r_txState)
            ST_IDLE: begin
               if (w_elig1 || w_elig2) begin
                  r_ch2     <= !w_elig1;
                  r_payload <= w_snap;
                  r_txData  <= w_elig1 ? TAG1 : TAG2;
                  r_txValid <= 1'b1;
                  r_txState <= ST_TAG;
               end
            end
            ST_TAG: begin
               if (w_accept) begin
                  r_txData  <= r_payload[7:0];
                  r_payload <= r_payload >> 8;
                  r_idx     <= '0;
                  r_txState <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_accept) begin
                  if (w_lastByte) begin
                     r_txValid <= 1'b0;
                     r_txState <= ST_IDLE;
                     if (r_ch2) r_sent2 <= 1'b1;
                     else       r_sent1 <= 1'b1;
                  end else begin
                     r_txData  <= r_payload[7:0];
                     r_payload <= r_payload >> 8;
                     r_idx     <= r_idx + c_IDX_W'(1);
                  end
               end
            end
            default: begin
               r_txValid <= 1'b0;
               r_txState <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oResetLatch1 <= 1'b0;
         oResetLatch2 <= 1'b0;
         oProtoErr    <= 1'b0;
      end else begin
         oResetLatch1 <= w_ack1Ok;
         oResetLatch2 <= w_ack2Ok;
         if (w_err) oProtoErr <= 1'b1;
      end
   end

   link_pulse_stretch #(
      .pLATCH_CYCLES (pLATCH_CYCLES)
   ) u_stretch1 (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iStart (w_trig1),
      .oLevel (oLatch1)
   );

   link_pulse_stretch #(
      .pLATCH_CYCLES (pLATCH_CYCLES)
   ) u_stretch2 (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iStart (w_trig2),
      .oLevel (oLatch2)
   );

endmodule
`default_nettype wire

// File: tb/tb_counter_link_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_link_engine
//  Brief    : Directed scoreboard bench for the counter link engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_link_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy1 = 1'b0;
   logic        rdy2 = 1'b0;
   logic [39:0] cnt1 = '0;
   logic [39:0] cnt2 = '0;
   logic        rl1, rl2, l1, l2, perr;

   counter_link_if link();

   counter_link_engine #(
      .pWIDTH        (40),
      .pLATCH_CYCLES (4)
   ) dut (
      .iCLK         (clk),
      .iRST         (rst),
      .iRdy1        (rdy1),
      .iCount1      (cnt1),
      .iRdy2        (rdy2),
      .iCount2      (cnt2),
      .oResetLatch1 (rl1),
      .oResetLatch2 (rl2),
      .oLatch1      (l1),
      .oLatch2      (l2),
      .oProtoErr    (perr),
      .link         (link)
   );

   always #5 clk = ~clk;

   int          nChecks = 0;
   int          nPass   = 0;
   logic [7:0]  txQ[$];
   // {resetLatch1, resetLatch2, latch1, latch2, protoErr}
   logic [4:0]  expSide = 5'b0;
   logic        stallPend = 1'b0;
   logic [7:0]  stallData = 8'h00;
   logic [9:0]  validPat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic pushFrame(input logic [7:0] tag, input logic [39:0] val);
      txQ.push_back(tag);
      for (int i = 0; i < 5; i++) txQ.push_back(val[8*i +: 8]);
   endtask

   task automatic rxCmd(input logic [7:0] b);
      link.rxData  = b;
      link.rxValid = 1'b1;
      @(posedge clk); #1;
      link.rxValid = 1'b0;
   endtask

   task automatic waitEmpty(input int budget);
      int n;
      n = 0;
      while (txQ.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (txQ.size() != 0) begin
         nChecks++;
         $display("FAIL frame_timeout: %0d bytes still pending, required 0", txQ.size());
         txQ.delete();
      end
   endtask

   // Monitor: sideband every cycle, TX bytes on each handshake
   always @(negedge clk) begin
      chk("sideband", 64'({rl1, rl2, l1, l2, perr}), 64'(expSide));
      if (stallPend)
         chk("stall_hold", 64'({link.txValid, link.txData}), 64'({1'b1, stallData}));
      if (link.txValid && link.txReady) begin
         if (txQ.size() == 0) begin
            nChecks++;
            $display("FAIL unexpected_byte: got %02h required no byte at %0t", link.txData, $time);
         end else begin
            chk("tx_byte", 64'(link.txData), 64'(txQ.pop_front()));
         end
      end
      stallPend = link.txValid && !link.txReady;
      stallData = link.txData;
   end

   initial begin
      link.txReady = 1'b1;
      link.rxValid = 1'b0;
      link.rxData  = 8'h00;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_txvalid", 64'(link.txValid), 64'(0));
      chk("reset_txdata", 64'(link.txData), 64'(0));
      rst = 1'b0;

      // Single frame at full rate, then no resend
      cnt1 = 40'h12_3456_789A;
      pushFrame(8'h00, cnt1);
      rdy1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         validPat[9-i] = link.txValid;
      end
      chk("valid_pattern", 64'(validPat), 64'(10'b0111111000));
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      chk("queue_drained_1", 64'(txQ.size()), 64'(0));

      // Ack releases register 1; new value then goes out
      rxCmd(8'h00);
      expSide[4] = 1'b1;
      rdy1 = 1'b0;
      @(posedge clk); #1;
      expSide[4] = 1'b0;
      cnt1 = 40'hAB_CDEF_0123;
      pushFrame(8'h00, cnt1);
      rdy1 = 1'b1;
      waitEmpty(50);
      repeat (3) @(posedge clk);
      #1;

      // Both channels at once under a half-rate sink
      rxCmd(8'h00);
      expSide[4] = 1'b1;
      rdy1 = 1'b0;
      @(posedge clk); #1;
      expSide[4] = 1'b0;
      cnt1 = 40'h01_0203_0405;
      cnt2 = 40'hF0_E0D0_C0B0;
      pushFrame(8'h00, cnt1);
      pushFrame(8'h01, cnt2);
      rdy1 = 1'b1;
      rdy2 = 1'b1;
      for (int i = 0; i < 200 && txQ.size() != 0; i++) begin
         @(posedge clk); #1;
         link.txReady = ~link.txReady;
      end
      waitEmpty(1);
      link.txReady = 1'b1;
      rdy1 = 1'b0;
      rdy2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Acks with ready flags already low still pulse
      rxCmd(8'h01);
      expSide[3] = 1'b1;
      @(posedge clk); #1;
      expSide[3] = 1'b0;
      rxCmd(8'h00);
      expSide[4] = 1'b1;
      @(posedge clk); #1;
      expSide[4] = 1'b0;

      // Trigger stretch with a restart on its second high cycle
      rxCmd(8'h02);
      expSide[2] = 1'b1;
      @(posedge clk); #1;
      rxCmd(8'h02);
      repeat (4) @(posedge clk);
      #1;
      expSide[2] = 1'b0;
      rxCmd(8'h03);
      expSide[1] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      expSide[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Ack for channel 2 with nothing sent
      rxCmd(8'h01);
      expSide[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of payload byte 2
      cnt1 = 40'h55_6677_8899;
      pushFrame(8'h00, cnt1);
      rdy1 = 1'b1;
      for (int i = 0; i < 50 && txQ.size() != 3; i++) begin
         @(negedge clk); #1;
      end
      chk("pre_reset_progress", 64'(txQ.size()), 64'(3));
      @(posedge clk); #2;
      rst = 1'b1;
      expSide = 5'b0;
      #1;
      chk("async_txvalid", 64'(link.txValid), 64'(0));
      chk("async_side", 64'({rl1, rl2, l1, l2, perr}), 64'(0));
      txQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      pushFrame(8'h00, cnt1);
      waitEmpty(50);
      repeat (2) @(posedge clk);
      #1;

      // Unknown command only raises the error flag
      rxCmd(8'h7F);
      expSide[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained_end", 64'(txQ.size()), 64'(0));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
